// File: rtl/branch_resolve_if.sv
// Bundles the branch resolve unit's pipeline controls, decode-stage branch info,
// the E-stage redirect and the M-stage predictor training/statistics outputs.
interface branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             stallE;
  logic             flushE;
  logic             stallM;
  logic             flushM;
  logic             branchD;
  logic             pred_takeD;
  logic [31:0]      pcD;
  logic [31:0]      targetD;
  logic             actual_takeE;
  logic             pred_wrongE;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             branchM;
  logic             actual_takeM;
  logic [31:0]      pcM;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stallE, flushE, stallM, flushM,
    output branchD, pred_takeD, pcD, targetD, actual_takeE,
    input  pred_wrongE, redirect_valid, redirect_pc,
    input  branchM, actual_takeM, pcM, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stallE, flushE, stallM, flushM,
    input  branchD, pred_takeD, pcD, targetD, actual_takeE,
    output pred_wrongE, redirect_valid, redirect_pc,
    output branchM, actual_takeM, pcM, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries the D-stage prediction through E and M: one-shot redirect in E, one-shot
// predictor training strobe in M. Define BRANCH_STATS_EN for saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter logic [31:0] FALLTHRU_OFFSET = 32'd8,
  parameter int          CNT_W           = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  logic        valid_e_q, valid_e_d;
  logic        pred_e_q, pred_e_d;
  logic [31:0] pc_e_q, pc_e_d;
  logic [31:0] target_e_q, target_e_d;
  logic        resolved_e_q, resolved_e_d;

  logic        valid_m_q, valid_m_d;
  logic        take_m_q, take_m_d;
  logic [31:0] pc_m_q, pc_m_d;
  logic        updated_m_q, updated_m_d;

  logic        mispred_e;
  logic        branch_m;

  // D->E register; resolved_e marks a held branch that has already redirected
  always_comb begin
    valid_e_d    = valid_e_q;
    pred_e_d     = pred_e_q;
    pc_e_d       = pc_e_q;
    target_e_d   = target_e_q;
    resolved_e_d = resolved_e_q;
    if (rst || bus.flushE) begin
      valid_e_d    = 1'b0;
      pred_e_d     = 1'b0;
      pc_e_d       = 32'd0;
      target_e_d   = 32'd0;
      resolved_e_d = 1'b0;
    end else if (!bus.stallE) begin
      valid_e_d    = bus.branchD;
      pred_e_d     = bus.pred_takeD & bus.branchD;
      pc_e_d       = bus.pcD;
      target_e_d   = bus.targetD;
      resolved_e_d = 1'b0;
    end else if (valid_e_q) begin
      resolved_e_d = 1'b1;
    end
  end

  assign mispred_e = valid_e_q & ~resolved_e_q & (pred_e_q != bus.actual_takeE);

  always_comb begin
    valid_m_d   = valid_m_q;
    take_m_d    = take_m_q;
    pc_m_d      = pc_m_q;
    updated_m_d = updated_m_q;
    if (rst || bus.flushM) begin
      valid_m_d   = 1'b0;
      take_m_d    = 1'b0;
      pc_m_d      = 32'd0;
      updated_m_d = 1'b0;
    end else if (!bus.stallM) begin
      updated_m_d = 1'b0;
      if (bus.stallE) begin
        valid_m_d = 1'b0;
        take_m_d  = 1'b0;
        pc_m_d    = 32'd0;
      end else begin
        valid_m_d = valid_e_q;
        take_m_d  = bus.actual_takeE;
        pc_m_d    = pc_e_q;
      end
    end else if (valid_m_q) begin
      updated_m_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    valid_e_q    <= valid_e_d;
    pred_e_q     <= pred_e_d;
    pc_e_q       <= pc_e_d;
    target_e_q   <= target_e_d;
    resolved_e_q <= resolved_e_d;
    valid_m_q    <= valid_m_d;
    take_m_q     <= take_m_d;
    pc_m_q       <= pc_m_d;
    updated_m_q  <= updated_m_d;
  end

  assign branch_m = valid_m_q & ~updated_m_q;

  always_comb begin
    bus.pred_wrongE    = mispred_e;
    bus.redirect_valid = mispred_e;
    bus.redirect_pc    = 32'd0;
    if (mispred_e)
      bus.redirect_pc = bus.actual_takeE ? target_e_q : (pc_e_q + FALLTHRU_OFFSET);
    bus.branchM      = branch_m;
    bus.actual_takeM = valid_m_q ? take_m_q : 1'b0;
    bus.pcM          = valid_m_q ? pc_m_q : 32'd0;
  end

`ifdef BRANCH_STATS_EN
  // The mispredict bit travels with the branch regardless of resolved_e, so a
  // stalled-then-released mispredict is still counted.
  logic             mispred_m_q, mispred_m_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    mispred_m_d = mispred_m_q;
    if (rst || bus.flushM)
      mispred_m_d = 1'b0;
    else if (!bus.stallM)
      mispred_m_d = bus.stallE ? 1'b0 : (valid_e_q & (pred_e_q != bus.actual_takeE));
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (rst) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (branch_m) begin
      if (branch_cnt_q != '1)
        branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispred_m_q && (mispred_cnt_q != '1))
        mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mispred_m_q   <= mispred_m_d;
    branch_cnt_q  <= branch_cnt_d;
    mispred_cnt_q <= mispred_cnt_d;
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: inputs change and outputs are checked
// on the falling edge, registers update on the rising edge.
module tb_branch_resolve_unit;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  branch_resolve_if #(.CNT_W(32)) bus ();

  branch_resolve_unit #(.FALLTHRU_OFFSET(32'd8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.stallE = 0; bus.flushE = 0; bus.stallM = 0; bus.flushM = 0;
    bus.branchD = 0; bus.pred_takeD = 0; bus.pcD = 0; bus.targetD = 0;
    bus.actual_takeE = 0;
  endtask

  task automatic issue(input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic act);
    bus.branchD = 1; bus.pred_takeD = pred; bus.pcD = pc; bus.targetD = tgt;
    bus.actual_takeE = act;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] b, input logic [31:0] m);
`ifdef BRANCH_STATS_EN
    chk({tag, "_branch_cnt"}, bus.branch_cnt, b);
    chk({tag, "_mispred_cnt"}, bus.mispred_cnt, m);
`else
    chk({tag, "_branch_cnt"}, bus.branch_cnt, 32'd0);
    chk({tag, "_mispred_cnt"}, bus.mispred_cnt, 32'd0);
    if (b == m) tests_run += 0;
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    idle();
    rst = 1;
    cyc(); cyc();
    chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_pred_wrong", {31'd0, bus.pred_wrongE}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_branchM", {31'd0, bus.branchM}, 32'd0);
    chk("rst_pcM", bus.pcM, 32'd0);
    chk("rst_actual_takeM", {31'd0, bus.actual_takeM}, 32'd0);
    chk_stats("rst", 32'd0, 32'd0);
    rst = 0;

    // correctly predicted taken
    issue(1, 32'h400, 32'h800, 1);
    cyc();
    chk("t1_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    bus.branchD = 0;
    cyc();
    chk("t1_M_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t1_M_pcM", bus.pcM, 32'h400);
    chk("t1_M_actual_takeM", {31'd0, bus.actual_takeM}, 32'd1);
    chk("t1_M_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    cyc();
    chk("t1_after_branchM", {31'd0, bus.branchM}, 32'd0);

    // predicted taken, actually not taken: fallthrough pc+8
    issue(1, 32'h1000, 32'h2000, 0);
    cyc();
    chk("t2_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t2_E_pred_wrong", {31'd0, bus.pred_wrongE}, 32'd1);
    chk("t2_E_redirect_pc", bus.redirect_pc, 32'h1008);
    bus.branchD = 0;
    cyc();
    chk("t2_M_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t2_M_actual_takeM", {31'd0, bus.actual_takeM}, 32'd0);
    chk("t2_M_pcM", bus.pcM, 32'h1000);
    chk("t2_M_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);

    // predicted not taken, actually taken: target
    issue(0, 32'h3000, 32'h2000, 1);
    cyc();
    chk("t3_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t3_E_redirect_pc", bus.redirect_pc, 32'h2000);
    bus.branchD = 0;
    cyc();
    chk("t3_next_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t3_next_redirect_pc", bus.redirect_pc, 32'd0);
    chk("t3_M_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t3_M_actual_takeM", {31'd0, bus.actual_takeM}, 32'd1);

    // mispredict held in E for three cycles
    issue(1, 32'h500, 32'h900, 0);
    cyc();
    chk("t4_E1_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t4_E1_redirect_pc", bus.redirect_pc, 32'h508);
    bus.branchD = 0;
    bus.stallE = 1;
    cyc();
    chk("t4_E2_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t4_E2_branchM", {31'd0, bus.branchM}, 32'd0);
    cyc();
    chk("t4_E3_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t4_E3_branchM", {31'd0, bus.branchM}, 32'd0);
    bus.stallE = 0;
    cyc();
    chk("t4_M_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t4_M_pcM", bus.pcM, 32'h500);
    chk("t4_M_actual_takeM", {31'd0, bus.actual_takeM}, 32'd0);
    chk("t4_M_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    cyc();
    chk("t4_after_branchM", {31'd0, bus.branchM}, 32'd0);

    // branch held in M for four cycles trains once
    issue(1, 32'h600, 32'h700, 1);
    cyc();
    bus.branchD = 0;
    cyc();
    chk("t5_M1_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t5_M1_pcM", bus.pcM, 32'h600);
    bus.stallM = 1;
    cyc();
    chk("t5_M2_branchM", {31'd0, bus.branchM}, 32'd0);
    chk("t5_M2_pcM_held", bus.pcM, 32'h600);
    chk_stats("t5_M2", 32'd5, 32'd3);
    cyc();
    chk("t5_M3_branchM", {31'd0, bus.branchM}, 32'd0);
    cyc();
    chk("t5_M4_branchM", {31'd0, bus.branchM}, 32'd0);
    bus.stallM = 0;
    cyc();
    chk("t5_release_branchM", {31'd0, bus.branchM}, 32'd0);
    chk_stats("t5_release", 32'd5, 32'd3);

    // flushE squashes the branch entering E
    issue(1, 32'h800, 32'h880, 0);
    bus.flushE = 1;
    cyc();
    chk("t6_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    bus.branchD = 0;
    bus.flushE = 0;
    cyc();
    chk("t6_M_branchM", {31'd0, bus.branchM}, 32'd0);

    // flushM overrides stallM
    issue(0, 32'hA00, 32'hB00, 0);
    cyc();
    chk("t7_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    bus.branchD = 0;
    cyc();
    chk("t7_M_branchM", {31'd0, bus.branchM}, 32'd1);
    bus.stallM = 1;
    bus.flushM = 1;
    cyc();
    chk("t7_flush_branchM", {31'd0, bus.branchM}, 32'd0);
    chk("t7_flush_pcM", bus.pcM, 32'd0);
    bus.stallM = 0;
    bus.flushM = 0;

    // fallthrough address wraps at 32 bits
    issue(1, 32'hFFFF_FFFC, 32'h1234, 0);
    cyc();
    chk("t8_E_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t8_E_redirect_pc", bus.redirect_pc, 32'h0000_0004);
    bus.branchD = 0;
    cyc();
    chk("t8_M_branchM", {31'd0, bus.branchM}, 32'd1);
    chk("t8_M_pcM", bus.pcM, 32'hFFFF_FFFC);
    cyc();
    chk_stats("final", 32'd7, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
